// File: rtl/fm_tx_pkg.sv
// fm_tx_pkg
// Shared encodings for the FM transmitter core.
//   chan_mode_e : audio source selection (left, right, mono mean, mute)
//   out_mode_e  : RF waveform shape (square or triangle)
//   LOCK_FRAMES : consecutive good stereo frames needed to declare lock
package fm_tx_pkg;

    typedef enum logic [1:0] {
        CH_LEFT  = 2'b00,
        CH_RIGHT = 2'b01,
        CH_MONO  = 2'b10,
        CH_MUTE  = 2'b11
    } chan_mode_e;

    typedef enum logic {
        OUT_SQUARE   = 1'b0,
        OUT_TRIANGLE = 1'b1
    } out_mode_e;

    localparam int LOCK_FRAMES = 2;

endpackage

// File: rtl/fm_tx_core_if.sv
// fm_tx_core_if
// I2S serial bus: bit clock, data and word select (ws=0 left, ws=1 right).
//   master : the I2S source driving the bus
//   slave  : the receiver inside fm_tx_core
interface fm_tx_core_if;

    logic i2s_clk;
    logic i2s_din;
    logic i2s_ws;

    modport master (output i2s_clk, output i2s_din, output i2s_ws);
    modport slave  (input  i2s_clk, input  i2s_din, input  i2s_ws);

endinterface

// File: rtl/fm_tx_core_i2s_os_rx.sv
// i2s_os_rx
// Oversampled I2S receiver running entirely in the clk domain.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   i2s         : I2S bus (slave modport), asynchronous to clk
//   bit_edge    : one-clk pulse per detected i2s_clk rising edge
//   word_vld    : one-clk pulse, a full-length word has ended
//   word_short  : one-clk pulse, a word ended with fewer than DW bits
//   word_is_r   : channel of the ended word (0 left, 1 right)
//   word_top    : top A bits of the ended word
module i2s_os_rx
    import fm_tx_pkg::*;
#(
    parameter int A  = 8,
    parameter int DW = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    fm_tx_core_if.slave  i2s,
    output logic         bit_edge,
    output logic         word_vld,
    output logic         word_short,
    output logic         word_is_r,
    output logic [A-1:0] word_top
);

    // [1:0] form the synchroniser, [2] is the history bit for edge detection.
    logic [2:0]    clk_sync;
    logic [1:0]    din_sync;
    logic [1:0]    ws_sync;

    // Holds the DW-1 bits preceding the current edge; the word is completed
    // by the bit sampled on the edge that ends it.
    logic [DW-2:0] shift_reg;
    logic [DW-1:0] shift_nxt;
    logic [5:0]    bit_cnt;
    logic [6:0]    word_bits;
    logic          ws_prev;
    logic          armed;
    logic          ws_chg;
    logic          too_short;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '0;
            din_sync <= '0;
            ws_sync  <= '0;
        end else begin
            clk_sync <= {clk_sync[1:0], i2s.i2s_clk};
            din_sync <= {din_sync[0], i2s.i2s_din};
            ws_sync  <= {ws_sync[0], i2s.i2s_ws};
        end
    end

    assign bit_edge  = clk_sync[1] & ~clk_sync[2];
    assign shift_nxt = {shift_reg, din_sync[1]};
    assign ws_chg    = bit_edge && (ws_sync[1] != ws_prev);
    assign word_bits = {1'b0, bit_cnt} + 7'd1;
    assign too_short = (word_bits < 7'(DW));

    // The first ws transition after reset only arms the receiver, so a word
    // already in flight at reset release is never reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            ws_prev    <= 1'b0;
            armed      <= 1'b0;
            word_vld   <= 1'b0;
            word_short <= 1'b0;
            word_is_r  <= 1'b0;
            word_top   <= '0;
        end else begin
            word_vld   <= 1'b0;
            word_short <= 1'b0;
            if (bit_edge) begin
                shift_reg <= shift_nxt[DW-2:0];
                ws_prev   <= ws_sync[1];
                if (ws_chg) begin
                    bit_cnt <= '0;
                    armed   <= 1'b1;
                    if (armed) begin
                        word_vld   <= !too_short;
                        word_short <= too_short;
                        word_is_r  <= ws_prev;
                        word_top   <= shift_nxt[DW-1 -: A];
                    end
                end else if (bit_cnt != 6'd63) begin
                    bit_cnt <= bit_cnt + 6'd1;
                end
            end
        end
    end

endmodule

// File: rtl/fm_tx_core.sv
// fm_tx_core
// I2S-fed FM modulator: audio from an I2S stream deviates a phase
// accumulator (NCO) whose phase drives a square or triangle DAC output.
//   clk, rst_n  : modulator clock, asynchronous active-low reset
//   i2s         : I2S bus (slave modport)
//   chan_mode   : 00 left, 01 right, 10 mono mean, 11 mute
//   out_mode    : 0 square, 1 triangle
//   carrier_inc : unsigned carrier phase increment per clk
//   dev_shift   : deviation left-shift applied to the audio sample
//   dac_mask    : AND mask on the DAC output
//   dac         : registered RF output
//   frame_valid : one-clk pulse per captured stereo frame
//   locked      : I2S stream healthy
module fm_tx_core
    import fm_tx_pkg::*;
#(
    parameter int A   = 8,
    parameter int DW  = 16,
    parameter int D   = 8,
    parameter int PW  = 24,
    parameter int TMO = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    fm_tx_core_if.slave   i2s,
    input  logic [1:0]    chan_mode,
    input  logic          out_mode,
    input  logic [PW-1:0] carrier_inc,
    input  logic [3:0]    dev_shift,
    input  logic [D-1:0]  dac_mask,
    output logic [D-1:0]  dac,
    output logic          frame_valid,
    output logic          locked
);

    localparam int TW = $clog2(TMO + 1);

    logic                 bit_edge, word_vld, word_short, word_is_r;
    logic [A-1:0]         word_top;
    // Only the top A bits of each word ever reach the modulator.
    logic signed [A-1:0]  l_word, r_word, audio_p0;
    logic                 l_seen, store_l, store_r;
    logic [1:0]           good_cnt, good_nxt;
    logic                 lock_nxt;
    logic [TW-1:0]        tmo_cnt;
    logic                 tmo_hit;
    logic [PW-1:0]        phase_p0;
    logic signed [PW-1:0] aud_ext, dev_term;
    logic [D-1:0]         tri_p0, sq_p0, dac_p1;

    function automatic logic signed [A-1:0] mean_trunc(input logic signed [A-1:0] a,
                                                       input logic signed [A-1:0] b);
        logic signed [A:0] sum;
        sum = {a[A-1], a} + {b[A-1], b};
        return sum[A:1];
    endfunction

    function automatic logic signed [A-1:0] pick_audio(input logic [1:0]          mode,
                                                       input logic signed [A-1:0] l,
                                                       input logic signed [A-1:0] r);
        logic signed [A-1:0] res;
        case (chan_mode_e'(mode))
            CH_LEFT:  res = l;
            CH_RIGHT: res = r;
            CH_MONO:  res = mean_trunc(l, r);
            default:  res = '0;
        endcase
        return res;
    endfunction

    i2s_os_rx #(.A(A), .DW(DW)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .i2s        (i2s),
        .bit_edge   (bit_edge),
        .word_vld   (word_vld),
        .word_short (word_short),
        .word_is_r  (word_is_r),
        .word_top   (word_top)
    );

    assign store_l = word_vld && !word_is_r;
    assign store_r = word_vld &&  word_is_r;
    assign tmo_hit = (tmo_cnt == TW'(TMO));

    // Good frames are counted since the last fault and saturate once locked.
    always_comb begin
        lock_nxt = locked;
        good_nxt = good_cnt;
        if (word_short || tmo_hit) begin
            lock_nxt = 1'b0;
            good_nxt = '0;
        end else if (frame_valid && (good_cnt != 2'(LOCK_FRAMES))) begin
            good_nxt = good_cnt + 2'd1;
            if (good_nxt == 2'(LOCK_FRAMES)) begin
                lock_nxt = 1'b1;
            end
        end
    end

    // ---- stage p0: frame assembly, lock tracking, audio sample ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt     <= '0;
            l_word      <= '0;
            r_word      <= '0;
            l_seen      <= 1'b0;
            frame_valid <= 1'b0;
            good_cnt    <= '0;
            locked      <= 1'b0;
            audio_p0    <= '0;
        end else begin
            if (bit_edge) begin
                tmo_cnt <= '0;
            end else if (!tmo_hit) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (store_l) l_word <= word_top;
            if (store_r) r_word <= word_top;
            if (store_l) begin
                l_seen <= 1'b1;
            end else if (store_r || word_short) begin
                l_seen <= 1'b0;
            end
            frame_valid <= store_r && l_seen;
            good_cnt    <= good_nxt;
            locked      <= lock_nxt;
            // An unlocked stream leaves the carrier unmodulated; chan_mode is
            // only looked at on a frame boundary.
            if (!lock_nxt) begin
                audio_p0 <= '0;
            end else if (frame_valid) begin
                audio_p0 <= pick_audio(chan_mode, l_word, r_word);
            end
        end
    end

    assign aud_ext  = {{(PW-A){audio_p0[A-1]}}, audio_p0};
    assign dev_term = aud_ext <<< dev_shift;

    // ---- stage p0: phase accumulator ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_p0 <= '0;
        end else begin
            phase_p0 <= phase_p0 + carrier_inc + dev_term;
        end
    end

    assign sq_p0  = {D{phase_p0[PW-1]}};
    assign tri_p0 = phase_p0[PW-2 -: D] ^ {D{phase_p0[PW-1]}};

    // ---- stage p1: waveform shaping and output mask ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_p1 <= '0;
        end else begin
            dac_p1 <= ((out_mode_e'(out_mode) == OUT_TRIANGLE) ? tri_p0 : sq_p0) & dac_mask;
        end
    end

    assign dac = dac_p1;

endmodule

// File: tb/tb_fm_tx_core.sv
// tb_fm_tx_core
// Directed self-checking bench for fm_tx_core: square carrier, channel
// selection, deviation, short words, lock timeout, mid-word reset and
// triangle output masking.
module tb_fm_tx_core;

    localparam int A   = 8;
    localparam int DW  = 16;
    localparam int D   = 8;
    localparam int PW  = 24;
    localparam int TMO = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    chan_mode;
    logic          out_mode;
    logic [PW-1:0] carrier_inc;
    logic [3:0]    dev_shift;
    logic [D-1:0]  dac_mask;
    logic [D-1:0]  dac;
    logic          frame_valid;
    logic          locked;

    int n_checks = 0;
    int n_pass   = 0;
    int fv_cnt   = 0;

    fm_tx_core_if i2s_bus ();

    fm_tx_core #(.A(A), .DW(DW), .D(D), .PW(PW), .TMO(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i2s         (i2s_bus),
        .chan_mode   (chan_mode),
        .out_mode    (out_mode),
        .carrier_inc (carrier_inc),
        .dev_shift   (dev_shift),
        .dac_mask    (dac_mask),
        .dac         (dac),
        .frame_valid (frame_valid),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_valid === 1'b1) fv_cnt <= fv_cnt + 1;
    end

    // One I2S bit lasts 8 clks; ws flips on the last bit of a word.
    task automatic send_word(input logic [15:0] data, input int nbits,
                             input logic ws_val, input bit end_word);
        for (int k = 0; k < nbits; k++) begin
            i2s_bus.i2s_clk = 1'b0;
            i2s_bus.i2s_din = data[15-k];
            i2s_bus.i2s_ws  = (end_word && k == nbits - 1) ? ~ws_val : ws_val;
            repeat (4) @(negedge clk);
            i2s_bus.i2s_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_word(l, 16, 1'b0, 1'b1);
        send_word(r, 16, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic get_inc(output logic [PW-1:0] inc);
        logic [PW-1:0] a;
        @(negedge clk);
        a = dut.phase_p0;
        @(negedge clk);
        inc = dut.phase_p0 - a;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        chan_mode       = 2'b11;
        out_mode        = 1'b0;
        carrier_inc     = 24'h100000;
        dev_shift       = 4'd0;
        dac_mask        = 8'hFF;
        i2s_bus.i2s_clk = 1'b1;
        i2s_bus.i2s_din = 1'b0;
        i2s_bus.i2s_ws  = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (dac !== 8'h00) $display("FAIL reset_dac: got %h want 00", dac); else n_pass++;
        n_checks++;
        if (frame_valid !== 1'b0) $display("FAIL reset_fv: got %b want 0", frame_valid); else n_pass++;
        n_checks++;
        if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else n_pass++;
        n_checks++;
        if (dut.phase_p0 !== 24'h0) $display("FAIL reset_phase: got %h want 000000", dut.phase_p0); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_square();
        logic [PW-1:0] ph_prev;
        logic [PW-1:0] inc;
        logic [D-1:0]  exp_dac;
        int            ones;
        ones    = 0;
        ph_prev = dut.phase_p0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            exp_dac = ph_prev[PW-1] ? 8'hFF : 8'h00;
            n_checks++;
            if (dac !== exp_dac) $display("FAIL square_dac[%0d]: got %h want %h", i, dac, exp_dac);
            else n_pass++;
            if (dac === 8'hFF) ones++;
            ph_prev = dut.phase_p0;
        end
        n_checks++;
        if (ones != 16) $display("FAIL square_duty: got %0d want 16 high of 32", ones); else n_pass++;
        get_inc(inc);
        n_checks++;
        if (inc !== 24'h100000) $display("FAIL square_inc: got %h want 100000", inc); else n_pass++;
    endtask

    task automatic test_channel_select();
        int fv0;
        chan_mode = 2'b10;
        fv0 = fv_cnt;
        send_frame(16'h4000, 16'hC000);
        send_frame(16'h4000, 16'hC000);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL lock_after_one_frame: got %b want 0", locked); else n_pass++;
        send_frame(16'h4000, 16'hC000);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL lock_after_two_frames: got %b want 1", locked); else n_pass++;
        n_checks++;
        if (fv_cnt - fv0 != 2) $display("FAIL frame_count: got %0d want 2", fv_cnt - fv0); else n_pass++;
        n_checks++;
        if (dut.audio_p0 !== 8'h00) $display("FAIL mono_audio: got %h want 00", dut.audio_p0); else n_pass++;
        chan_mode = 2'b00;
        repeat (10) @(negedge clk);
        n_checks++;
        if (dut.audio_p0 !== 8'h00) $display("FAIL mode_hold: got %h want 00", dut.audio_p0); else n_pass++;
        send_frame(16'h4000, 16'hC000);
        n_checks++;
        if (dut.audio_p0 !== 8'h40) $display("FAIL left_audio: got %h want 40", dut.audio_p0); else n_pass++;
    endtask

    task automatic test_deviation();
        logic [PW-1:0] inc;
        dev_shift = 4'd4;
        chan_mode = 2'b00;
        send_frame(16'h7F00, 16'h0000);
        n_checks++;
        if (dut.audio_p0 !== 8'h7F) $display("FAIL dev_audio: got %h want 7f", dut.audio_p0); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            get_inc(inc);
            n_checks++;
            if (inc !== 24'h1007F0) $display("FAIL dev_inc_pos[%0d]: got %h want 1007f0", i, inc);
            else n_pass++;
        end
        chan_mode = 2'b01;
        dev_shift = 4'd2;
        send_frame(16'h7F00, 16'hC000);
        n_checks++;
        if (dut.audio_p0 !== 8'hC0) $display("FAIL right_audio: got %h want c0", dut.audio_p0); else n_pass++;
        get_inc(inc);
        n_checks++;
        if (inc !== 24'h0FFF00) $display("FAIL dev_inc_neg: got %h want 0fff00", inc); else n_pass++;
    endtask

    task automatic test_short_word();
        int fv0;
        chan_mode = 2'b00;
        dev_shift = 4'd0;
        fv0 = fv_cnt;
        send_word(16'h7F00, 12, 1'b0, 1'b1);
        send_word(16'h4000, 16, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL short_unlock: got %b want 0", locked); else n_pass++;
        n_checks++;
        if (fv_cnt != fv0) $display("FAIL short_no_frame: got %0d want %0d", fv_cnt, fv0); else n_pass++;
        n_checks++;
        if (dut.audio_p0 !== 8'h00) $display("FAIL short_audio: got %h want 00", dut.audio_p0); else n_pass++;
        send_frame(16'h2000, 16'h0000);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL relock_one: got %b want 0", locked); else n_pass++;
        send_frame(16'h2000, 16'h0000);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL relock_two: got %b want 1", locked); else n_pass++;
        n_checks++;
        if (dut.audio_p0 !== 8'h20) $display("FAIL relock_audio: got %h want 20", dut.audio_p0); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [PW-1:0] inc;
        dev_shift = 4'd3;
        get_inc(inc);
        n_checks++;
        if (inc !== 24'h100100) $display("FAIL mod_inc: got %h want 100100", inc); else n_pass++;
        repeat (880) @(negedge clk);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL tmo_early: got %b want 1", locked); else n_pass++;
        repeat (200) @(negedge clk);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL tmo_unlock: got %b want 0", locked); else n_pass++;
        get_inc(inc);
        n_checks++;
        if (inc !== 24'h100000) $display("FAIL tmo_carrier: got %h want 100000", inc); else n_pass++;
    endtask

    task automatic test_reset_mid_word();
        int fv0;
        chan_mode = 2'b00;
        send_word(16'h4000, 8, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dac !== 8'h00) $display("FAIL midrst_dac: got %h want 00", dac); else n_pass++;
        n_checks++;
        if (frame_valid !== 1'b0) $display("FAIL midrst_fv: got %b want 0", frame_valid); else n_pass++;
        n_checks++;
        if (locked !== 1'b0) $display("FAIL midrst_locked: got %b want 0", locked); else n_pass++;
        n_checks++;
        if (dut.phase_p0 !== 24'h0) $display("FAIL midrst_phase: got %h want 000000", dut.phase_p0); else n_pass++;
        rst_n = 1'b1;
        fv0 = fv_cnt;
        send_word(16'h0000, 8, 1'b0, 1'b1);
        send_word(16'hC000, 16, 1'b1, 1'b1);
        send_frame(16'h4000, 16'hC000);
        send_frame(16'h4000, 16'hC000);
        n_checks++;
        if (fv_cnt - fv0 != 2) $display("FAIL recapture_frames: got %0d want 2", fv_cnt - fv0); else n_pass++;
        n_checks++;
        if (locked !== 1'b1) $display("FAIL recapture_locked: got %b want 1", locked); else n_pass++;
        n_checks++;
        if (dut.audio_p0 !== 8'h40) $display("FAIL recapture_audio: got %h want 40", dut.audio_p0); else n_pass++;
    endtask

    task automatic test_triangle_mask();
        logic [PW-1:0] ph_prev;
        logic [D-1:0]  exp_dac;
        out_mode = 1'b1;
        dac_mask = 8'h0F;
        ph_prev  = dut.phase_p0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            exp_dac = (ph_prev[22:15] ^ {8{ph_prev[23]}}) & 8'h0F;
            n_checks++;
            if (dac !== exp_dac) $display("FAIL tri_dac[%0d]: got %h want %h", i, dac, exp_dac);
            else n_pass++;
            n_checks++;
            if ((dac & 8'hF0) !== 8'h00) $display("FAIL tri_upper[%0d]: got %h want 0x", i, dac);
            else n_pass++;
            ph_prev = dut.phase_p0;
        end
    endtask

    initial begin
        test_reset();
        test_square();
        test_channel_select();
        test_deviation();
        test_short_word();
        test_timeout();
        test_reset_mid_word();
        test_triangle_mask();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
